// File: rtl/player_move_ctrl_pkg.sv
// Shared VGA geometry, button bit positions and the per-axis step/clamp helper
// used by the sprite movement controller.
package player_move_ctrl_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam int BTN_UP    = 3;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 0;

  typedef logic [9:0] coord_t;

  // One frame step on one axis; widened to 11 bits so pos+step cannot wrap
  // before the clamp. Opposite directions held together cancel.
  function automatic coord_t step_axis(input coord_t pos, input logic inc,
                                       input logic dec, input logic [10:0] step,
                                       input logic [10:0] max_pos);
    logic [10:0] wide;
    logic [10:0] res;
    wide = {1'b0, pos};
    res  = wide;
    if (inc && !dec) begin
      res = wide + step;
      if (res > max_pos) res = max_pos;
    end else if (dec && !inc) begin
      res = (wide < step) ? 11'd0 : (wide - step);
    end
    return coord_t'(res);
  endfunction

endpackage

// File: rtl/player_move_ctrl_if.sv
// Bundle of the button, VGA-counter and sprite-position signals between the
// movement controller and its neighbours.
interface player_move_ctrl_if;
  import player_move_ctrl_pkg::*;

  logic   up;
  logic   down;
  logic   left;
  logic   right;
  coord_t col;
  coord_t row;
  coord_t pos_x;
  coord_t pos_y;
  logic   moving;
  logic [3:0] btn_state;

  modport master (output up, down, left, right, col, row,
                  input  pos_x, pos_y, moving, btn_state);
  modport slave  (input  up, down, left, right, col, row,
                  output pos_x, pos_y, moving, btn_state);
endinterface

// File: rtl/player_move_ctrl_button_debounce.sv
// Two-flop synchroniser plus hold-time debouncer for one raw pushbutton.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic Master_Clock_In,
  input  logic Reset_N_In,
  input  logic Btn_In,
  output logic Btn_Out
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q, btn_d;

  // The count restarts whenever the synced level agrees with the output, so
  // any glitch shorter than the hold period never reaches the output.
  always_comb begin
    sync_d = {sync_q[0], Btn_In};
    cnt_d  = '0;
    btn_d  = btn_q;
    if (sync_q[1] != btn_q) begin
      if (cnt_q == CNT_LAST) begin
        btn_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      sync_q <= '0;
      cnt_q  <= '0;
      btn_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      btn_q  <= btn_d;
    end
  end

  assign Btn_Out = btn_q;

endmodule

// File: rtl/player_move_ctrl.sv
// Sprite movement controller: debounced buttons move the sprite once per frame
// during vertical blanking, clamped so it stays fully on the visible area.
module player_move_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int STEP            = 4,
  parameter int H_ACTIVE        = player_move_ctrl_pkg::H_ACTIVE,
  parameter int V_ACTIVE        = player_move_ctrl_pkg::V_ACTIVE,
  parameter int SPRITE_W        = 32,
  parameter int SPRITE_H        = 32,
  parameter int X_INIT          = 304,
  parameter int Y_INIT          = 224
) (
  input  logic       Master_Clock_In,
  input  logic       Reset_N_In,
  input  logic       Up,
  input  logic       Down,
  input  logic       Left,
  input  logic       Right,
  input  logic [9:0] Val_Col_In,
  input  logic [9:0] Val_Row_In,
  output logic [9:0] Pos_X_Out,
  output logic [9:0] Pos_Y_Out,
  output logic       Moving_Out,
  output logic [3:0] Btn_State_Out
);
  import player_move_ctrl_pkg::*;

  localparam logic [10:0] MAX_X  = 11'(H_ACTIVE - SPRITE_W);
  localparam logic [10:0] MAX_Y  = 11'(V_ACTIVE - SPRITE_H);
  localparam logic [10:0] STEP_W = 11'(STEP);

  logic [3:0] btn_raw;
  logic [3:0] btn_db;

  assign btn_raw[BTN_UP]    = Up;
  assign btn_raw[BTN_DOWN]  = Down;
  assign btn_raw[BTN_LEFT]  = Left;
  assign btn_raw[BTN_RIGHT] = Right;

  for (genvar i = 0; i < 4; i++) begin : g_db
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .Master_Clock_In (Master_Clock_In),
      .Reset_N_In      (Reset_N_In),
      .Btn_In          (btn_raw[i]),
      .Btn_Out         (btn_db[i])
    );
  end

  logic   tick_q, tick_d;
  coord_t pos_x_q, pos_x_d;
  coord_t pos_y_q, pos_y_d;
  logic   moving_q, moving_d;

  // First blanking line at column 0 happens once per frame; the update follows
  // one cycle later so the position never changes inside the active picture.
  always_comb begin
    tick_d   = (Val_Row_In == 10'(V_ACTIVE)) && (Val_Col_In == 10'd0);
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    moving_d = moving_q;
    if (tick_q) begin
      pos_x_d  = step_axis(pos_x_q, btn_db[BTN_RIGHT], btn_db[BTN_LEFT], STEP_W, MAX_X);
      pos_y_d  = step_axis(pos_y_q, btn_db[BTN_DOWN], btn_db[BTN_UP], STEP_W, MAX_Y);
      moving_d = (pos_x_d != pos_x_q) || (pos_y_d != pos_y_q);
    end
  end

  always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      tick_q   <= 1'b0;
      pos_x_q  <= coord_t'(X_INIT);
      pos_y_q  <= coord_t'(Y_INIT);
      moving_q <= 1'b0;
    end else begin
      tick_q   <= tick_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      moving_q <= moving_d;
    end
  end

  assign Pos_X_Out     = pos_x_q;
  assign Pos_Y_Out     = pos_y_q;
  assign Moving_Out    = moving_q;
  assign Btn_State_Out = btn_db;

endmodule

// File: doc/player_move_ctrl.md
Name: player_move_ctrl

Overview:
- Upstream neighbour of the VGA draw stage.
- Takes the raw BTNU/BTND/BTNL/BTNR pushbuttons and synchronises and debounces them.
- Updates a sprite position once per frame, clamped to the visible area, and presents a stable position for the draw stage.
- Runs on the 25 MHz pixel clock and takes the column/row counters from the VGA controller.

Parameters:
DEBOUNCE_CYCLES, 250000, cycles a synced button must hold a new level before the debounced level changes (10 ms at 25 MHz)
STEP, 4, pixels moved per frame per held direction
H_ACTIVE, 640, visible columns
V_ACTIVE, 480, visible rows
SPRITE_W, 32, sprite width in pixels
SPRITE_H, 32, sprite height in pixels
X_INIT, 304, reset X (top-left corner)
Y_INIT, 224, reset Y (top-left corner)

Ports:
Master_Clock_In  input  1  25 MHz pixel clock; the only clock
Reset_N_In  input  1  asynchronous, active-low reset
Up  input  1  raw button, asynchronous, active-high
Down  input  1  raw button, asynchronous, active-high
Left  input  1  raw button, asynchronous, active-high
Right  input  1  raw button, asynchronous, active-high
Val_Col_In  input  10  current column from the VGA controller
Val_Row_In  input  10  current row from the VGA controller
Pos_X_Out  output  10  sprite top-left X, 0..H_ACTIVE-SPRITE_W
Pos_Y_Out  output  10  sprite top-left Y, 0..V_ACTIVE-SPRITE_H
Moving_Out  output  1  1 if the last frame update changed the position
Btn_State_Out  output  4  debounced buttons {Up,Down,Left,Right}

Behaviour:
- Reset is asynchronous and active-low. On assertion, immediately:
  - Pos_X_Out=X_INIT, Pos_Y_Out=Y_INIT
  - Moving_Out=0, Btn_State_Out=0
  - all synchroniser flops, counters and the tick register cleared to 0
- Synchroniser: two flops per button, reset to 0.
- Debounce, per button, with counter width $clog2(DEBOUNCE_CYCLES):
  - if synced == debounced, the counter clears
  - otherwise the counter increments
  - when the counter reaches DEBOUNCE_CYCLES-1 while synced != debounced, debounced takes the synced value and the counter clears the same cycle
  - any glitch shorter than DEBOUNCE_CYCLES resets the count; no change is output
  - latency from a clean input edge to Btn_State_Out = 2 + DEBOUNCE_CYCLES cycles
- Frame tick:
  - registered one-cycle pulse, asserted the cycle after Val_Row_In==V_ACTIVE && Val_Col_In==0
  - exactly one tick per frame, always in vertical blanking
  - no tick while in reset
- Position update, on the cycle after the tick:
  - dx = Right − Left, dy = Down − Up, using debounced values, each in {−1,0,+1}
  - opposite buttons held together cancel to 0 on that axis
  - both axes update in the same cycle, independently
  - arithmetic is done in 11-bit unsigned to avoid wrap
  - +: new = min(pos+STEP, MAX), with MAX_X = H_ACTIVE−SPRITE_W and MAX_Y = V_ACTIVE−SPRITE_H
  - −: new = (pos < STEP) ? 0 : pos−STEP
  - result is truncated to 10 bits (always fits)
  - outputs are otherwise held, so the position is constant through the whole active frame
- Moving_Out is updated only on tick cycles: 1 iff the new X != old X or the new Y != old Y. Being clamped at an edge with the button held gives 0.
- Button changes between ticks have no effect until the next tick; there is no auto-repeat beyond one step per frame.
- Reset mid-frame or mid-debounce: everything is reinitialised as above. A button held through reset must re-debounce the full period before it can move the sprite.
- If the VGA controller is held in reset, the row never reaches V_ACTIVE, no tick fires, and the position freezes.

Decomposition:
- Shared package (vga_pkg):
  - H_ACTIVE, V_ACTIVE
  - button index constants BTN_UP=3, BTN_DOWN=2, BTN_LEFT=1, BTN_RIGHT=0
  - 10-bit coordinate typedef
- Sub-module button_debounce:
  - contains the synchroniser and counter
  - parameter DEBOUNCE_CYCLES
  - ports Master_Clock_In, Reset_N_In, Btn_In, Btn_Out
  - instantiated four times
- Top-level player_move_ctrl holds the tick generator, position registers and clamp logic.

Test Plan:
(All scenarios run with DEBOUNCE_CYCLES=8, driving a VGA counter model at 800x525.)
1. Reset released, no buttons -> Pos=(304,224) and Moving_Out=0 across 3 frames; one tick per frame, only at row 480/col 0.
2. Right with a 5-cycle glitch -> Btn_State_Out stays 0. Then Right held -> bit0 rises exactly 10 cycles after the edge; at the next tick Pos_X=308 and Moving_Out=1; Pos_X stays constant between ticks.
3. Left+Right held together over 2 frames -> Pos_X unchanged and Moving_Out=0. Same for Up+Down on Y.
4. Start at Pos_X=604, hold Right -> 608 after one frame, then stays 608 with Moving_Out=0. Start at Pos_Y=446, hold Down -> 448 and holds there.
5. Start at Pos_Y=2, hold Up -> 0 and holds. Up+Right held together -> X and Y both change in the same cycle.
6. Down held, Reset_N_In pulsed low mid-frame, asynchronously to the clock -> outputs return to (304,224) within the pulse, with no clock edge needed. After release, Btn_State_Out bit2 takes 10 cycles to re-assert, and there is no Y move before the first tick after that.
